keypad_alu_core: RTL and testbench

//   Parametrised calculator datapath: scans a 4x4 hex keypad, debounces it and shifts accepted hex

---
 rtl/keypad_alu_core.sv | 166 ++++++++++++++++
 tb/tb_keypad_alu_core.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_alu_core.sv
// keypad_alu_core: 4x4 hex keypad scanner/debouncer, digit entry register,
// NREGS x WIDTH register file and a registered 8-op ALU with flags.
module keypad_alu_core #(
    parameter int WIDTH    = 8,
    parameter int NREGS    = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       kp_col,
    output logic [3:0]       kp_row,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [AW-1:0]    rd_a,
    input  logic [AW-1:0]    rd_b,
    input  logic [2:0]       op,
    output logic             key_valid,
    output logic [3:0]       key_code,
    output logic [WIDTH-1:0] entry,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             zero,
    output logic             neg
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);

    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DBNC = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    row_idx;
    logic [1:0]    col_sel;
    logic [1:0]    col_idx;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH+3:0] shifted;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   res;

    assign kp_row = 4'b0001 << row_idx;

    always_comb begin
        col_idx = 2'd0;
        if (kp_col[0])      col_idx = 2'd0;
        else if (kp_col[1]) col_idx = 2'd1;
        else if (kp_col[2]) col_idx = 2'd2;
        else if (kp_col[3]) col_idx = 2'd3;
    end

    // Detect cycle counts as the first stable cycle of a press or release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_SCAN;
            row_idx   <= 2'd0;
            col_sel   <= 2'd0;
            div       <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                S_SCAN: begin
                    if (kp_col != 4'd0) begin
                        col_sel <= col_idx;
                        cnt     <= CW'(1);
                        state   <= S_DBNC;
                    end else if (div == DIV_LAST) begin
                        div     <= '0;
                        row_idx <= row_idx + 2'd1;
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                S_DBNC: begin
                    if (!kp_col[col_sel]) begin
                        state   <= S_SCAN;
                        row_idx <= row_idx + 2'd1;
                        div     <= '0;
                    end else if (cnt >= DB_LAST) begin
                        key_valid <= 1'b1;
                        key_code  <= {row_idx, col_sel};
                        state     <= S_HELD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HELD: begin
                    if (kp_col == 4'd0) begin
                        cnt   <= CW'(1);
                        state <= S_REL;
                    end
                end
                default: begin
                    if (kp_col != 4'd0) begin
                        state <= S_HELD;
                    end else if (cnt >= DB_LAST) begin
                        state   <= S_SCAN;
                        row_idx <= row_idx + 2'd1;
                        div     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign shifted = {entry, key_code};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wr_en) regs[wr_addr] <= entry;
            if (key_valid)
                entry <= wr_en ? WIDTH'(key_code) : shifted[WIDTH-1:0];
            else if (wr_en)
                entry <= '0;
        end
    end

    assign a = regs[rd_a];
    assign b = regs[rd_b];

    always_comb begin
        res = '0;
        unique case (op)
            3'd0: res = {1'b0, a} + {1'b0, b};
            3'd1: res = {1'b0, a} - {1'b0, b};
            3'd2: res = {1'b0, a & b};
            3'd3: res = {1'b0, a | b};
            3'd4: res = {1'b0, a ^ b};
            3'd5: res = {a, 1'b0};
            3'd6: res = {a[0], 1'b0, a[WIDTH-1:1]};
            3'd7: res = {1'b0, a};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            alu_out <= res[WIDTH-1:0];
            carry   <= res[WIDTH];
            zero    <= (res[WIDTH-1:0] == '0);
            neg     <= res[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_keypad_alu_core.sv
// Bench for keypad_alu_core: keypad model, key/ALU scoreboards,
// ALU vector table and hand sequences for bounce, reset and commit.
module tb_keypad_alu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [3:0] kp_col8, kp_row8;
    logic       wr_en8;
    logic [1:0] wr_addr8, rd_a8, rd_b8;
    logic [2:0] op8;
    logic       key_valid8;
    logic [3:0] key_code8;
    logic [7:0] entry8, alu_out8;
    logic       carry8, zero8, neg8;

    logic [3:0]  kp_col16, kp_row16;
    logic        wr_en16;
    logic [2:0]  wr_addr16, rd_a16, rd_b16;
    logic [2:0]  op16;
    logic        key_valid16;
    logic [3:0]  key_code16;
    logic [15:0] entry16, alu_out16;
    logic        carry16, zero16, neg16;

    keypad_alu_core dut8 (
        .clk(clk), .reset(reset), .kp_col(kp_col8), .kp_row(kp_row8),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .rd_a(rd_a8), .rd_b(rd_b8),
        .op(op8), .key_valid(key_valid8), .key_code(key_code8),
        .entry(entry8), .alu_out(alu_out8), .carry(carry8),
        .zero(zero8), .neg(neg8)
    );

    keypad_alu_core #(.WIDTH(16), .NREGS(8), .SCAN_DIV(4)) dut16 (
        .clk(clk), .reset(reset), .kp_col(kp_col16), .kp_row(kp_row16),
        .wr_en(wr_en16), .wr_addr(wr_addr16), .rd_a(rd_a16), .rd_b(rd_b16),
        .op(op16), .key_valid(key_valid16), .key_code(key_code16),
        .entry(entry16), .alu_out(alu_out16), .carry(carry16),
        .zero(zero16), .neg(neg16)
    );

    // Keypad model: a pressed key closes its column only while its row is driven.
    logic       pressed [2];
    logic [1:0] prow [2];
    logic [1:0] pcol [2];

    assign kp_col8  = (pressed[0] && kp_row8[prow[0]])  ? (4'b0001 << pcol[0]) : 4'b0000;
    assign kp_col16 = (pressed[1] && kp_row16[prow[1]]) ? (4'b0001 << pcol[1]) : 4'b0000;

    int checks = 0;
    int failures = 0;
    int kv_cnt0 = 0;
    int kv_cnt1 = 0;

    logic [3:0] kq8[$];
    logic [3:0] kq16[$];

    typedef struct packed {
        logic [15:0] out;
        logic        c;
        logic        z;
        logic        n;
    } alu_exp_t;
    alu_exp_t aq[$];

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] op;
        logic [7:0] out;
        logic       c;
        logic       z;
        logic       n;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        logic [4:0] e;
        @(negedge clk);
        if (key_valid8 === 1'b1) begin
            kv_cnt0++;
            e = (kq8.size() != 0) ? {1'b0, kq8.pop_front()} : 5'h1F;
            chk("key8_code", {28'd0, key_code8}, {27'd0, e});
        end
        if (key_valid16 === 1'b1) begin
            kv_cnt1++;
            e = (kq16.size() != 0) ? {1'b0, kq16.pop_front()} : 5'h1F;
            chk("key16_code", {28'd0, key_code16}, {27'd0, e});
        end
    end

    task automatic wait_kv(input int d);
        int n = 0;
        while (((d == 0) ? key_valid8 : key_valid16) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(d == 0 ? "kv8_seen" : "kv16_seen",
            {31'd0, (d == 0) ? key_valid8 : key_valid16}, 32'd1);
    endtask

    task automatic press(input int d, input logic [1:0] r, input logic [1:0] c,
                         input logic do_wr, input logic [2:0] wa);
        if (d == 0) kq8.push_back({r, c});
        else        kq16.push_back({r, c});
        prow[d] = r;
        pcol[d] = c;
        pressed[d] = 1'b1;
        wait_kv(d);
        if (do_wr) begin
            if (d == 0) begin wr_en8 = 1'b1; wr_addr8 = wa[1:0]; end
            else        begin wr_en16 = 1'b1; wr_addr16 = wa; end
            @(negedge clk);
            wr_en8 = 1'b0;
            wr_en16 = 1'b0;
        end
        repeat (4) @(negedge clk);
        pressed[d] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic commit(input int d, input logic [2:0] wa);
        if (d == 0) begin wr_en8 = 1'b1; wr_addr8 = wa[1:0]; end
        else        begin wr_en16 = 1'b1; wr_addr16 = wa; end
        @(negedge clk);
        wr_en8 = 1'b0;
        wr_en16 = 1'b0;
    endtask

    task automatic alu(input int d, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] o, input logic [15:0] eo,
                       input logic ec, input logic ez, input logic en,
                       input string name);
        alu_exp_t e;
        if (d == 0) begin rd_a8 = ra[1:0]; rd_b8 = rb[1:0]; op8 = o; end
        else        begin rd_a16 = ra; rd_b16 = rb; op16 = o; end
        aq.push_back({eo, ec, ez, en});
        @(negedge clk);
        e = aq.pop_front();
        if (d == 0) begin
            chk({name, "_out"}, {24'd0, alu_out8}, {16'd0, e.out});
            chk({name, "_flags"}, {29'd0, carry8, zero8, neg8}, {29'd0, e.c, e.z, e.n});
        end else begin
            chk({name, "_out"}, {16'd0, alu_out16}, {16'd0, e.out});
            chk({name, "_flags"}, {29'd0, carry16, zero16, neg16}, {29'd0, e.c, e.z, e.n});
        end
    endtask

    initial begin
        int base;
        int n;

        tbl[0]  = '{2'd0, 2'd1, 3'd0, 8'h10, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2'd1, 2'd0, 3'd1, 8'h30, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 2'd0, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'd0, 2'd0, 3'd5, 8'hE0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{2'd0, 2'd1, 3'd1, 8'hD0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{2'd0, 2'd1, 3'd2, 8'h20, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'd0, 2'd2, 3'd3, 8'hF7, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{2'd0, 2'd0, 3'd6, 8'h78, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'd2, 2'd0, 3'd6, 8'h03, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{2'd3, 2'd0, 3'd7, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{2'd1, 2'd2, 3'd0, 8'h27, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'd2, 2'd2, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pressed[i] = 1'b0;
            prow[i] = 2'd0;
            pcol[i] = 2'd0;
        end
        wr_en8 = 1'b0; wr_addr8 = '0; rd_a8 = '0; rd_b8 = '0; op8 = '0;
        wr_en16 = 1'b0; wr_addr16 = '0; rd_a16 = '0; rd_b16 = '0; op16 = '0;

        repeat (3) @(negedge clk);
        chk("rst_kp_row", {28'd0, kp_row8}, 32'h1);
        chk("rst_entry", {24'd0, entry8}, 32'h0);
        chk("rst_alu_out", {24'd0, alu_out8}, 32'h0);
        chk("rst_flags", {29'd0, carry8, zero8, neg8}, 32'h0);
        chk("rst_key", {27'd0, key_valid8, key_code8}, 32'h0);
        chk("rst_kp_row16", {28'd0, kp_row16}, 32'h1);
        chk("rst_entry16", {16'd0, entry16}, 32'h0);

        reset = 1'b0;
        @(negedge clk);
        prow[0] = 2'd0; pcol[0] = 2'd1; pressed[0] = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        pressed[0] = 1'b0;
        @(negedge clk);
        chk("midrst_kp_row", {28'd0, kp_row8}, 32'h1);
        chk("midrst_alu_zero", {23'd0, alu_out8, zero8}, 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_pulse", kv_cnt0, 0);
        chk("midrst_entry", {24'd0, entry8}, 32'h0);

        press(0, 2'd2, 2'd2, 1'b0, 3'd0);
        chk("entry_0A", {24'd0, entry8}, 32'h0A);
        press(0, 2'd1, 2'd1, 1'b0, 3'd0);
        chk("entry_A5", {24'd0, entry8}, 32'hA5);

        commit(0, 3'd1);
        chk("commit_entry_clr", {24'd0, entry8}, 32'h0);
        alu(0, 3'd1, 3'd0, 3'd7, 16'h00A5, 1'b0, 1'b0, 1'b1, "pass_r1");

        press(0, 2'd1, 2'd3, 1'b0, 3'd0);
        chk("entry_07", {24'd0, entry8}, 32'h07);
        press(0, 2'd0, 2'd3, 1'b1, 3'd2);
        chk("same_edge_entry", {24'd0, entry8}, 32'h03);
        alu(0, 3'd2, 3'd0, 3'd7, 16'h0007, 1'b0, 1'b0, 1'b0, "same_edge_r2");

        press(0, 2'd3, 2'd3, 1'b0, 3'd0);
        press(0, 2'd0, 2'd0, 1'b0, 3'd0);
        chk("entry_F0", {24'd0, entry8}, 32'hF0);
        commit(0, 3'd0);
        press(0, 2'd0, 2'd2, 1'b0, 3'd0);
        press(0, 2'd0, 2'd0, 1'b0, 3'd0);
        chk("entry_20", {24'd0, entry8}, 32'h20);
        commit(0, 3'd1);

        for (int i = 0; i < 12; i++)
            alu(0, {1'b0, tbl[i].a}, {1'b0, tbl[i].b}, tbl[i].op,
                {8'd0, tbl[i].out}, tbl[i].c, tbl[i].z, tbl[i].n,
                $sformatf("vec%0d", i));

        n = 0;
        while (kp_row8 !== 4'b0100 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bounce_row2_reached", {28'd0, kp_row8}, 32'h4);
        base = kv_cnt0;
        prow[0] = 2'd2; pcol[0] = 2'd2;
        pressed[0] = 1'b1;
        repeat (2) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("bounce_row_adv", {28'd0, kp_row8}, 32'h8);
        for (int i = 0; i < 3; i++) begin
            pressed[0] = 1'b1;
            repeat (2) @(negedge clk);
            pressed[0] = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_key", kv_cnt0, base);

        base = kv_cnt0;
        kq8.push_back(4'h9);
        prow[0] = 2'd2; pcol[0] = 2'd1;
        pressed[0] = 1'b1;
        wait_kv(0);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pressed[0] = 1'b0;
            repeat (2) @(negedge clk);
            pressed[0] = 1'b1;
            repeat (2) @(negedge clk);
        end
        pressed[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_single_pulse", kv_cnt0, base + 1);

        press(1, 2'd0, 2'd1, 1'b0, 3'd0);
        press(1, 2'd0, 2'd2, 1'b0, 3'd0);
        press(1, 2'd0, 2'd3, 1'b0, 3'd0);
        press(1, 2'd1, 2'd0, 1'b0, 3'd0);
        chk("w16_entry_1234", {16'd0, entry16}, 32'h1234);
        press(1, 2'd1, 2'd1, 1'b0, 3'd0);
        chk("w16_entry_2345", {16'd0, entry16}, 32'h2345);
        commit(1, 3'd7);
        chk("w16_entry_clr", {16'd0, entry16}, 32'h0);
        alu(1, 3'd7, 3'd0, 3'd7, 16'h2345, 1'b0, 1'b0, 1'b0, "w16_pass_r7");
        alu(1, 3'd7, 3'd7, 3'd0, 16'h468A, 1'b0, 1'b0, 1'b0, "w16_add_r7");
        alu(1, 3'd0, 3'd7, 3'd1, 16'hDCBB, 1'b1, 1'b0, 1'b1, "w16_sub_borrow");

        repeat (2) @(negedge clk);
        chk("key8_queue_empty", kq8.size(), 0);
        chk("key16_queue_empty", kq16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
